// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: default reset PC,
// default queue depth, NOP encoding and the fetch queue entry layout.
package fetch_pkg;

  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] FETCH_NOP      = 32'h0000_0013;
  localparam int unsigned FETCH_QDEPTH   = 4;

  // One fetch queue slot: the PC is known at allocation, the instruction
  // arrives later and sets 'filled'.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        filled;
  } fetch_entry_t;

  // Force an address onto a word boundary.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// In-order fetch queue. Slots are allocated at the tail when a request is
// accepted, filled in allocation order as responses return, and popped from
// the head once filled. A flush frees every slot in one cycle.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned QDEPTH = FETCH_QDEPTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      alloc,
  input  logic [31:0]               alloc_pc,
  input  logic                      fill,
  input  logic [31:0]               fill_instr,
  input  logic                      pop,
  output logic                      head_valid,
  output logic [31:0]               head_pc,
  output logic [31:0]               head_instr,
  output logic [$clog2(QDEPTH):0]   count,
  output logic [$clog2(QDEPTH):0]   unfilled
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = PW + 1;

  fetch_entry_t  entries_q [QDEPTH];
  fetch_entry_t  entries_d [QDEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW-1:0] fill_q, fill_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] unfilled_q, unfilled_d;

  // Next-state for storage, the three pointers and the two occupancy counts.
  always_comb begin
    entries_d  = entries_q;
    head_d     = head_q;
    tail_d     = tail_q;
    fill_d     = fill_q;
    count_d    = count_q;
    unfilled_d = unfilled_q;
    if (flush) begin
      head_d     = '0;
      tail_d     = '0;
      fill_d     = '0;
      count_d    = '0;
      unfilled_d = '0;
    end else begin
      if (alloc) begin
        entries_d[tail_q] = '{pc: alloc_pc, instr: FETCH_NOP, filled: 1'b0};
        tail_d            = tail_q + 1'b1;
      end
      if (fill) begin
        entries_d[fill_q].instr  = fill_instr;
        entries_d[fill_q].filled = 1'b1;
        fill_d                   = fill_q + 1'b1;
      end
      if (pop) begin
        head_d = head_q + 1'b1;
      end
      count_d    = count_q + CW'(alloc) - CW'(pop);
      unfilled_d = unfilled_q + CW'(alloc) - CW'(fill);
    end
  end

  // Queue state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(QDEPTH); i++) begin
        entries_q[i] <= '0;
      end
      head_q     <= '0;
      tail_q     <= '0;
      fill_q     <= '0;
      count_q    <= '0;
      unfilled_q <= '0;
    end else begin
      for (int i = 0; i < int'(QDEPTH); i++) begin
        entries_q[i] <= entries_d[i];
      end
      head_q     <= head_d;
      tail_q     <= tail_d;
      fill_q     <= fill_d;
      count_q    <= count_d;
      unfilled_q <= unfilled_d;
    end
  end

  assign head_valid = (count_q != '0) && entries_q[head_q].filled;
  assign head_pc    = entries_q[head_q].pc;
  assign head_instr = entries_q[head_q].instr;
  assign count      = count_q;
  assign unfilled   = unfilled_q;

endmodule

// File: rtl/fetch_stage.sv
// Decoupled instruction fetch stage. Owns the PC, issues sequential word
// fetches, buffers returned instructions in fetch_queue and hands them to
// decode. A redirect flushes the queue and arms a drop counter that discards
// the responses of requests issued before the redirect.
// Optional build macro FETCH_PERF_CNT_EN adds perf_fetch_cnt/perf_stall_cnt.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
  parameter int unsigned QDEPTH   = FETCH_QDEPTH
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam int unsigned CW = $clog2(QDEPTH) + 1;

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;

  logic [CW-1:0] q_count;
  logic [CW-1:0] q_unfilled;
  logic          q_head_valid;
  logic [31:0]   q_head_pc;
  logic [31:0]   q_head_instr;
  logic [CW:0]   in_use;
  logic          req_fire;
  logic          pop;
  logic          fill;

  // Queued slots plus responses still to be dropped may never exceed the
  // queue depth, which keeps every outstanding request countable in CW bits.
  assign in_use = {1'b0, q_count} + {1'b0, drop_cnt_q};

  assign imem_req_valid = reset && !redirect_valid
                          && (q_count < CW'(QDEPTH))
                          && (in_use < (CW+1)'(QDEPTH));
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign if_valid = q_head_valid;
  assign if_pc    = q_head_valid ? q_head_pc    : '0;
  assign if_instr = q_head_valid ? q_head_instr : '0;

  assign pop  = q_head_valid && id_ready && !redirect_valid;
  assign fill = imem_rsp_valid && !redirect_valid && (drop_cnt_q == '0);

  fetch_queue #(
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect_valid),
    .alloc      (req_fire),
    .alloc_pc   (pc_q),
    .fill       (fill),
    .fill_instr (imem_rsp_data),
    .pop        (pop),
    .head_valid (q_head_valid),
    .head_pc    (q_head_pc),
    .head_instr (q_head_instr),
    .count      (q_count),
    .unfilled   (q_unfilled)
  );

  // PC advance and drop counter; a redirect overrides everything else and a
  // response arriving with it is consumed on the spot instead of being counted.
  always_comb begin
    pc_d       = pc_q;
    drop_cnt_d = drop_cnt_q;
    if (redirect_valid) begin
      pc_d       = align_word(redirect_pc);
      drop_cnt_d = q_unfilled + drop_cnt_q - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) begin
        pc_d = pc_q + 32'd4;
      end
      if (imem_rsp_valid && (drop_cnt_q != '0)) begin
        drop_cnt_d = drop_cnt_q - 1'b1;
      end
    end
  end

  // PC and drop counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      drop_cnt_q <= '0;
    end else begin
      pc_q       <= pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Count instructions handed to decode and cycles decode held one back.
  always_comb begin
    perf_fetch_d = perf_fetch_q + 32'(pop);
    perf_stall_d = perf_stall_q + 32'(if_valid && !id_ready);
  end

  // Performance counter registers, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

`ifndef SYNTHESIS
  rsp_has_request: assert property (@(posedge clk) disable iff (!reset)
    imem_rsp_valid |-> ((drop_cnt_q != '0) || (q_unfilled != '0)));
`endif

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Decoupled instruction fetch stage that sits directly upstream of instruction decode in the baseline pipeline. It owns the PC and issues sequential word fetches to instruction memory over a request/response interface. Returned instructions are buffered in an in-order fetch queue and presented to decode with a valid/ready handshake. A redirect from execute flushes the queue and discards in-flight responses.

## Interface
- `RESET_PC`, 32'h0000_0000: PC fetched first after reset.
- `QDEPTH`, 4: fetch queue entries, power of two, ≥2.

Ports:
- `clk`  in  1  clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `imem_req_valid`  out  1  fetch request.
- `imem_req_addr`  out  32  word-aligned fetch address.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_rsp_valid`  in  1  response, in request order, ≥1 cycle after acceptance.
- `imem_rsp_data`  in  32  instruction word.
- `redirect_valid`  in  1  control-flow redirect.
- `redirect_pc`  in  32  redirect target.
- `if_valid`  out  1  instruction available to decode.
- `if_instr`  out  32  instruction.
- `if_pc`  out  32  PC of `if_instr`.
- `id_ready`  in  1  decode accepts.

## Operation
- Request accepted when `imem_req_valid && imem_req_ready`; PC += 4, a queue slot is allocated at tail with its PC.
- `imem_req_valid` = (allocated slots < QDEPTH) && !`redirect_valid` && (drop_cnt == 0 or drop path permits, see below); forced 0 during reset.
- Response fills oldest allocated-but-unfilled slot. Head is output when filled; pop on `if_valid && id_ready`.
- Redirect: all slots freed, PC ← {`redirect_pc`[31:2], 2'b00}; drop_cnt ← number of outstanding (accepted, unanswered) requests. Responses with drop_cnt > 0 are discarded and decrement drop_cnt. New requests may issue during draining; their responses are identified by drop_cnt reaching 0 first.
- Redirect has priority over pop, request and fill in the same cycle; a response arriving on the redirect cycle counts as old and is discarded (excluded from drop_cnt).
- drop_cnt, slot counters are $clog2(QDEPTH)+1 bits; pointers wrap modulo QDEPTH.
- No response without outstanding request: undefined, asserted in simulation.

## Timing
- Reset values: PC = RESET_PC, queue empty, drop_cnt = 0, `if_valid` = 0, `if_instr` = 0, `if_pc` = 0, `imem_req_valid` = 0.
- First cycle after reset release: `imem_req_valid` = 1, `imem_req_addr` = RESET_PC.
- Request accepted cycle N, response cycle N+1 → `if_valid` cycle N+2 (registered queue, no bypass).
- Sustained 1 instr/cycle with 1-cycle memory and `id_ready` = 1 requires QDEPTH ≥ 3.
- Redirect in cycle N: `if_valid` = 0 in N+1; request for target issued in N+1.
- Reset asserted mid-operation: all state cleared immediately; in-flight memory responses after release are memory's responsibility to suppress.
- Outputs stable while `if_valid && !id_ready`.

## Configuration
- `FETCH_PERF_CNT_EN`: adds outputs `perf_fetch_cnt` (32, instructions popped to decode) and `perf_stall_cnt` (32, cycles with `if_valid && !id_ready`), both reset to 0, wrap at 2^32, cleared by reset only. Without the macro, ports and counters are absent; behaviour otherwise identical.

## Structure
- Shared package `fetch_pkg`: default RESET_PC, NOP constant 32'h0000_0013, queue entry type {pc[31:0], instr[31:0], filled}.
- One sub-module: `fetch_queue` (circular buffer with alloc/fill/pop/flush pointers and counts); PC, drop logic and handshake in `fetch_stage`.

## Test plan
- Reset release, memory always ready, 1-cycle latency, `id_ready` = 1 → PCs 0x0,0x4,0x8… to decode, one per cycle from cycle 2.
- Hold `id_ready` = 0 for 10 cycles → at most QDEPTH requests accepted, `if_pc` = 0x0 held stable, no loss after release.
- Redirect to 0x103 with 2 outstanding requests → next two responses dropped, first decoded `if_pc` = 0x100.
- Redirect same cycle as response and pop → response discarded, head not popped twice, queue empty next cycle.
- Memory latency randomised 1–5 cycles, `imem_req_ready` randomised → decoded stream equals sequential PC/instruction model.
- Assert reset mid-stream → all outputs return to reset values same cycle; after release, fetch restarts at RESET_PC; with `FETCH_PERF_CNT_EN`, counters read 0.
